// File: rtl/boss_pkg.sv
// Shared constants and types for the boss sprite pixel pipeline.
package boss_pkg;

  // Default sprite dimensions. The sprite RAM holds BOSS_SPR_W*BOSS_SPR_H words.
  localparam int BOSS_SPR_W = 185;
  localparam int BOSS_SPR_H = 150;

  // This palette index means "no boss here".
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  // Sixteen 24-bit RGB entries, indexed by the 4-bit value read from the sprite RAM.
  typedef logic [15:0][23:0] palette_t;

  // The concatenation lists entry 15 first and entry 0 (black) last.
  localparam palette_t BOSS_PALETTE = {
    24'hF8F8F8,  // 15
    24'hC0C0C0,  // 14
    24'h606060,  // 13
    24'h30C030,  // 12
    24'h1080F0,  // 11
    24'h2040A0,  // 10
    24'hF0A040,  //  9
    24'hA05020,  //  8
    24'hFFE040,  //  7
    24'hE02020,  //  6
    24'h901818,  //  5
    24'h602080,  //  4
    24'h402060,  //  3
    24'h281838,  //  2
    24'h100810,  //  1
    24'h000000   //  0 (transparent)
  };

endpackage

// File: rtl/boss_flash_ctr.sv
// Hit-flash frame counter. A hit reloads the count; each frame start counts it
// down to zero. The flash is white for four frames, then normal for four, and so on.
module boss_flash_ctr #(
  parameter int FLASH_FRAMES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit,
  input  logic frame_start,
  output logic flash_white
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [CNT_W-1:0] flash_cnt_q;
  logic [CNT_W-1:0] flash_cnt_d;

  // Next count: a hit reloads and wins over a simultaneous frame-start decrement.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (hit) begin
      flash_cnt_d = CNT_W'(FLASH_FRAMES);
    end else if (frame_start && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash_white = (flash_cnt_q != '0) && flash_cnt_q[2];

endmodule

// File: rtl/boss_sprite_renderer.sv
// Boss sprite pixel stage. It computes the sprite RAM address from the pixel
// coordinate, then turns the returned palette index into boss_on and RGB.
// There is a fixed latency of three cycles from coordinate to colour.
module boss_sprite_renderer
  import boss_pkg::*;
#(
  parameter int SPR_W        = BOSS_SPR_W,
  parameter int SPR_H        = BOSS_SPR_H,
  parameter int ADDR_W       = 19,
  parameter int FLASH_FRAMES = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [9:0]        boss_x,
  input  logic [9:0]        boss_y,
  input  logic              facing_left,
  input  logic              hit,
  output logic [ADDR_W-1:0] read_address,
  input  logic [3:0]        data_Out,
  output logic              boss_on,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);

  localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S = 11'(SPR_H);

  // Position and facing, held for the whole frame.
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic       mir_q, mir_d;

  // Stage 1 combinational terms.
  logic signed [10:0] dx, dy, col;
  logic               in_box;
  logic               flash_white;

  // Pipeline registers.
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              in_box_d1_q, in_box_d1_d;
  logic              flash_white_d1_q, flash_white_d1_d;
  logic              in_box_d2_q, in_box_d2_d;
  logic              flash_white_d2_q, flash_white_d2_d;
  logic              boss_on_q, boss_on_d;
  logic [23:0]       rgb_q, rgb_d;

  boss_flash_ctr #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .hit        (hit),
    .frame_start(frame_start),
    .flash_white(flash_white)
  );

  // Box test, mirrored column, and address. Also the frame latch, the delay line and the colour stage.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    mir_d   = mir_q;
    if (frame_start) begin
      pos_x_d = boss_x;
      pos_y_d = boss_y;
      mir_d   = facing_left;
    end

    // Zero-extend to 11 bits before subtracting. A boss near the right edge then
    // gives a negative dx for pixels to its left and never wraps around.
    dx     = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x_q});
    dy     = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y_q});
    in_box = !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);
    col    = mir_q ? (SPR_W_S - 11'sd1 - dx) : dx;

    read_address_d = '0;
    if (in_box) begin
      read_address_d = ADDR_W'($unsigned(dy)) * ADDR_W'(SPR_W) + ADDR_W'($unsigned(col));
    end

    // Flash is sampled together with in_box, so every pixel keeps one consistent colour.
    in_box_d1_d      = in_box;
    flash_white_d1_d = flash_white;
    in_box_d2_d      = in_box_d1_q;
    flash_white_d2_d = flash_white_d1_q;

    // data_Out lines up with stage 2 because the RAM returns it one cycle after the address.
    boss_on_d = in_box_d2_q && (data_Out != TRANSPARENT_IDX);
    rgb_d     = '0;
    if (boss_on_d) begin
      rgb_d = flash_white_d2_q ? 24'hFFFFFF : BOSS_PALETTE[data_Out];
    end
  end

  // All pipeline and frame state. An asynchronous clear blanks the outputs at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q          <= '0;
      pos_y_q          <= '0;
      mir_q            <= 1'b0;
      read_address_q   <= '0;
      in_box_d1_q      <= 1'b0;
      flash_white_d1_q <= 1'b0;
      in_box_d2_q      <= 1'b0;
      flash_white_d2_q <= 1'b0;
      boss_on_q        <= 1'b0;
      rgb_q            <= '0;
    end else begin
      pos_x_q          <= pos_x_d;
      pos_y_q          <= pos_y_d;
      mir_q            <= mir_d;
      read_address_q   <= read_address_d;
      in_box_d1_q      <= in_box_d1_d;
      flash_white_d1_q <= flash_white_d1_d;
      in_box_d2_q      <= in_box_d2_d;
      flash_white_d2_q <= flash_white_d2_d;
      boss_on_q        <= boss_on_d;
      rgb_q            <= rgb_d;
    end
  end

  assign read_address = read_address_q;
  assign boss_on      = boss_on_q;
  assign Red          = rgb_q[23:16];
  assign Green        = rgb_q[15:8];
  assign Blue         = rgb_q[7:0];

endmodule

// File: tb/tb_boss_sprite_renderer.sv
// Self-checking bench for boss_sprite_renderer.
// A bench-side model pushes the expected pixel colour as each coordinate is driven.
// The expectation is popped and compared when the DUT output for that pixel appears.
module tb_boss_sprite_renderer;
  import boss_pkg::*;

  localparam int MODEL_SPR_W = 185;
  localparam int MODEL_SPR_H = 150;
  localparam int MODEL_FLASH = 32;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start;
  logic [9:0]  boss_x, boss_y;
  logic        facing_left;
  logic        hit;
  logic [18:0] read_address;
  logic [3:0]  data_Out;
  logic        boss_on;
  logic [7:0]  Red, Green, Blue;

  boss_sprite_renderer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .boss_x      (boss_x),
    .boss_y      (boss_y),
    .facing_left (facing_left),
    .hit         (hit),
    .read_address(read_address),
    .data_Out    (data_Out),
    .boss_on     (boss_on),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite RAM model. Each word's content is its address modulo 16.
  always @(posedge Clk) data_Out <= read_address[3:0];

  typedef struct {
    bit          chk;
    int          x;
    int          y;
    logic [24:0] exp;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state tracked by the bench.
  int m_pos_x = 0, m_pos_y = 0, m_cnt = 0;
  bit m_mir = 1'b0;

  function automatic bit model_inbox(int x, int y);
    int dx = x - m_pos_x;
    int dy = y - m_pos_y;
    return (dx >= 0) && (dx < MODEL_SPR_W) && (dy >= 0) && (dy < MODEL_SPR_H);
  endfunction

  function automatic int model_addr(int x, int y);
    int dx = x - m_pos_x;
    int dy = y - m_pos_y;
    int c  = m_mir ? (MODEL_SPR_W - 1 - dx) : dx;
    if (!model_inbox(x, y)) return 0;
    return dy * MODEL_SPR_W + c;
  endfunction

  function automatic logic [24:0] model_pix(int x, int y);
    int          idx   = model_addr(x, y) % 16;
    bit          on    = model_inbox(x, y) && (idx != 0);
    bit          white = (m_cnt != 0) && (((m_cnt >> 2) & 1) == 1);
    logic [23:0] rgb   = 24'h0;
    if (on) rgb = white ? 24'hFFFFFF : BOSS_PALETTE[idx];
    return {on, rgb};
  endfunction

  task automatic step(input int x, input int y, input bit fs, input bit h,
                      input bit chk, input bit chk_addr);
    ent_t        e;
    logic [18:0] exp_addr;
    logic [24:0] got;
    e.chk    = chk;
    e.x      = x;
    e.y      = y;
    e.exp    = model_pix(x, y);
    exp_addr = 19'(model_addr(x, y));
    sb.push_back(e);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    hit         = h;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    hit         = 1'b0;
    if (h) m_cnt = MODEL_FLASH;
    else if (fs && m_cnt != 0) m_cnt = m_cnt - 1;
    if (fs) begin
      m_pos_x = int'(boss_x);
      m_pos_y = int'(boss_y);
      m_mir   = facing_left;
    end
    if (chk_addr) begin
      n_checks++;
      if (read_address !== exp_addr)
        $display("[TB] FAIL read_address (%0d,%0d): got %0d expected %0d", x, y, read_address, exp_addr);
      else n_pass++;
    end
    if (sb.size() == 3) begin
      e = sb.pop_front();
      if (e.chk) begin
        got = {boss_on, Red, Green, Blue};
        n_checks++;
        if (got !== e.exp)
          $display("[TB] FAIL pixel (%0d,%0d) at t=%0t: got on=%0b rgb=%06h expected on=%0b rgb=%06h",
                   e.x, e.y, $time, got[24], got[23:0], e.exp[24], e.exp[23:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic latch_frame(input int bx, input int by, input bit left);
    boss_x      = 10'(bx);
    boss_y      = 10'(by);
    facing_left = left;
    step(639, 479, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_outputs_zero(input string what);
    n_checks++;
    if ({boss_on, Red, Green, Blue, read_address} !== '0)
      $display("[TB] FAIL %s: got on=%0b rgb=%02h%02h%02h addr=%0d expected all zero",
               what, boss_on, Red, Green, Blue, read_address);
    else n_pass++;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs_zero("reset_state");
    Reset_n = 1'b1;
    // After reset the sprite sits at (0,0), unmirrored: (1,1) maps to address 186.
    step(1, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(2, 0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_position_latch();
    $display("[TB] test_position_latch");
    latch_frame(100, 50, 1'b0);
    step(100, 50, 1'b0, 1'b0, 1'b1, 1'b1);
    step(101, 50, 1'b0, 1'b0, 1'b1, 1'b1);
    step(284, 199, 1'b0, 1'b0, 1'b1, 1'b1);
    step(285, 199, 1'b0, 1'b0, 1'b1, 1'b1);
    step(99, 50, 1'b0, 1'b0, 1'b1, 1'b1);
    step(150, 200, 1'b0, 1'b0, 1'b1, 1'b1);
    // Live inputs change without a frame start, so the latched position must stay.
    boss_x = 10'd0;
    boss_y = 10'd0;
    step(110, 60, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mirror();
    $display("[TB] test_mirror");
    latch_frame(0, 0, 1'b1);
    step(0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(184, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(7, 3, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_palette();
    $display("[TB] test_palette");
    latch_frame(0, 0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(5, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 16; i < 32; i++) step(i, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_hit_flash();
    $display("[TB] test_hit_flash");
    latch_frame(0, 0, 1'b0);
    step(5, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      step(5, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_hit_frame_coincide();
    $display("[TB] test_hit_frame_coincide");
    step(5, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(5, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_offscreen();
    $display("[TB] test_offscreen");
    latch_frame(600, 0, 1'b0);
    for (int x = 0; x < 640; x++) step(x, 10, 1'b0, 1'b0, 1'b1, 1'b0);
    latch_frame(500, 400, 1'b1);
    for (int y = 470; y < 480; y++) step(510, y, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 300; i++) begin
      bit fs = ($urandom_range(0, 19) == 0);
      bit h  = ($urandom_range(0, 29) == 0);
      if (fs) begin
        boss_x      = 10'($urandom_range(0, 639));
        boss_y      = 10'($urandom_range(0, 479));
        facing_left = 1'($urandom_range(0, 1));
      end
      step(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), fs, h, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_midline();
    $display("[TB] test_reset_midline");
    latch_frame(0, 0, 1'b0);
    step(5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(6, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(7, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(9, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    sb.delete();
    m_pos_x = 0;
    m_pos_y = 0;
    m_mir   = 1'b0;
    m_cnt   = 0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    step(1, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(3, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    step(300, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    DrawX       = '0;
    DrawY       = '0;
    frame_start = 1'b0;
    boss_x      = '0;
    boss_y      = '0;
    facing_left = 1'b0;
    hit         = 1'b0;
    Reset_n     = 1'b1;
    #2;
    test_reset();
    test_position_latch();
    test_mirror();
    test_palette();
    test_hit_flash();
    test_hit_frame_coincide();
    test_offscreen();
    test_back_to_back();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
